// File: rtl/shift_rotate_unit_pkg.sv
// shift_rotate_unit_pkg: shared op/state encodings and FLAGS bit positions for the shift/rotate unit
package shift_rotate_unit_pkg;
    typedef enum logic [2:0] {SHL, SHR, SAR, ROL, ROR, RCL, RCR} ShiftOp_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int CF_IDX = 0;
    localparam int PF_IDX = 2;
    localparam int AF_IDX = 4;
    localparam int ZF_IDX = 6;
    localparam int SF_IDX = 7;
    localparam int OF_IDX = 11;
endpackage

// File: rtl/shift_step.sv
// shift_step: applies k (0..STEP) single-bit shift/rotate steps to {CF, value}
module shift_step
    import shift_rotate_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  ShiftOp_t         op,
    input  logic             is_8_bit,
    input  logic [3:0]       k,
    input  logic             cf,
    input  logic [WIDTH-1:0] val,
    output logic             next_cf,
    output logic [WIDTH-1:0] next_val
);
    function automatic logic [WIDTH:0] step1(ShiftOp_t o, logic b8, logic [WIDTH:0] s);
        logic [WIDTH-1:0] v, msk, top;
        logic c, msb, left, fill;
        {c, v} = s;
        msk  = b8 ? WIDTH'(8'hFF) : '1;
        top  = b8 ? WIDTH'(8'h80) : WIDTH'(1) << (WIDTH - 1);
        msb  = |(v & top);
        left = o inside {SHL, ROL, RCL};
        case (o)
            SAR, ROL: fill = msb;
            ROR:      fill = v[0];
            RCL, RCR: fill = c;
            default:  fill = 1'b0;
        endcase
        if (o > RCR) return s;
        return left ? {msb, ((v << 1) | WIDTH'(fill)) & msk}
                    : {v[0], (v >> 1) | (fill ? top : '0)};
    endfunction

    always_comb begin
        logic [WIDTH:0] s;
        s = {cf, val};
        for (int i = 0; i < STEP; i++) s = (4'(i) < k) ? step1(op, is_8_bit, s) : s;
        {next_cf, next_val} = s;
    end
endmodule

// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: iterative multi-cycle shift/rotate unit with start/busy/done handshake
module shift_rotate_unit
    import shift_rotate_unit_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int STEP       = 1,
    parameter bit MASK_COUNT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  ShiftOp_t         op,
    input  logic             is_8_bit,
    input  logic [WIDTH-1:0] a,
    input  logic [7:0]       count,
    input  logic [15:0]      flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [15:0]      flags_out
);
    state_t           state;
    ShiftOp_t         op_r;
    logic             b8_r, cf, next_cf;
    logic [WIDTH-1:0] a_r, val, next_val, a_m;
    logic [7:0]       rem, n;
    logic [3:0]       k;
    logic [15:0]      fl_r, new_flags;
    logic             a_msb, a_msb2, r_msb;

    assign n    = MASK_COUNT ? {3'b0, count[4:0]} : count;
    assign a_m  = is_8_bit ? WIDTH'(a[7:0]) : a;
    assign k    = (rem < 8'(STEP)) ? rem[3:0] : 4'(STEP);
    assign busy = state != IDLE;

    shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .op(op_r), .is_8_bit(b8_r), .k(k), .cf(cf), .val(val),
        .next_cf(next_cf), .next_val(next_val)
    );

    // Flags for the final step; OF is defined from the original operand, not the last step
    always_comb begin
        a_msb  = b8_r ? a_r[7] : a_r[WIDTH-1];
        a_msb2 = b8_r ? a_r[6] : a_r[WIDTH-2];
        r_msb  = b8_r ? next_val[7] : next_val[WIDTH-1];
        new_flags         = fl_r;
        new_flags[CF_IDX] = next_cf;
        new_flags[SF_IDX] = r_msb;
        new_flags[ZF_IDX] = next_val == '0;
        new_flags[PF_IDX] = ~^next_val[7:0];
        new_flags[OF_IDX] = (op_r == SHL) ? a_msb ^ r_msb :
                            (op_r == SHR) ? a_msb :
                            (op_r inside {ROL, RCL}) ? a_msb ^ a_msb2 :
                            (op_r == ROR) ? a_msb ^ a_r[0] :
                            (op_r == RCR) ? a_msb ^ fl_r[CF_IDX] : 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            done      <= 1'b0;
            out       <= '0;
            flags_out <= '0;
            op_r      <= SHL;
            b8_r      <= 1'b0;
            a_r       <= '0;
            val       <= '0;
            cf        <= 1'b0;
            rem       <= '0;
            fl_r      <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else if (state == RUN) begin
                val <= next_val;
                cf  <= next_cf;
                rem <= rem - 8'(k);
                if (rem == 8'(k)) begin
                    state     <= DONE;
                    done      <= 1'b1;
                    out       <= next_val;
                    flags_out <= new_flags;
                end
            end else if (start) begin
                op_r <= op;
                b8_r <= is_8_bit;
                a_r  <= a_m;
                val  <= a_m;
                cf   <= flags_in[CF_IDX];
                rem  <= n;
                fl_r <= flags_in;
                if (n == 8'd0) begin
                    state     <= DONE;
                    done      <= 1'b1;
                    out       <= a_m;
                    flags_out <= flags_in;
                end else begin
                    state <= RUN;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_shift_rotate_unit.sv
// tb_shift_rotate_unit: scoreboard bench for two unit configurations against an arithmetic reference model
module tb_shift_rotate_unit;
    import shift_rotate_unit_pkg::*;

    typedef struct packed {logic [31:0] o; logic [15:0] f; int due;} exp_t;
    typedef struct packed {ShiftOp_t op; logic b8; logic [31:0] a; logic [7:0] c; logic [15:0] f; logic bb;} vec_t;

    localparam int NDIR = 10;
    localparam int NRND = 160;

    logic clk = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(int id, string nm, logic [63:0] act, logic [63:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL inst%0d %s: got 0x%0h required 0x%0h", id, nm, act, req);
        end
    endfunction

    function automatic vec_t dvec(int j);
        case (j)
            0: return '{SHL, 1'b0, 32'h8001, 8'd1,   16'h0000, 1'b0};
            1: return '{RCR, 1'b1, 32'h0001, 8'd9,   16'h0000, 1'b0};
            2: return '{SAR, 1'b0, 32'h8000, 8'd0,   16'h0F55, 1'b0};
            3: return '{SHR, 1'b0, 32'hFFFF, 8'h21,  16'h0000, 1'b0};
            4: return '{ROL, 1'b0, 32'h1234, 8'd8,   16'h0000, 1'b0};
            5: return '{ROR, 1'b0, 32'h1234, 8'd8,   16'h0000, 1'b1};
            6: return '{SAR, 1'b1, 32'h0080, 8'd0,   16'hFFFF, 1'b1};
            7: return '{SAR, 1'b0, 32'h8421, 8'd20,  16'h0000, 1'b0};
            8: return '{RCL, 1'b0, 32'hABCD, 8'd17,  16'h0001, 1'b0};
            default: return '{SHL, 1'b1, 32'h00C3, 8'd200, 16'h0010, 1'b0};
        endcase
    endfunction

    // Reference: whole-count shifts/rotations on a w-bit value held in 64 bits
    function automatic logic [47:0] model(int w, ShiftOp_t op, logic [31:0] ain, int n, logic [15:0] fi);
        logic [63:0] m, a, r, t, ring, rm;
        logic signed [63:0] sa;
        logic c;
        int k;
        logic [15:0] f;
        m = (64'd1 << w) - 1;
        a = {32'd0, ain} & m;
        if (n == 0) return {a[31:0], fi};
        sa = a[w-1] ? $signed(a | ~m) : $signed(a);
        rm = (m << 1) | 64'd1;
        ring = a | (64'(fi[CF_IDX]) << w);
        r = a;
        c = fi[CF_IDX];
        case (op)
            SHL: begin r = a << n; c = r[w]; end
            SHR: begin r = a >> n; t = a >> (n - 1); c = t[0]; end
            SAR: begin
                r = sa >>> (n > 63 ? 63 : n);
                t = sa >>> (n - 1 > 63 ? 63 : n - 1);
                c = t[0];
            end
            ROL: begin k = n % w; r = ((a << k) | (a >> (w - k))) & m; c = r[0]; end
            ROR: begin k = n % w; r = ((a >> k) | (a << (w - k))) & m; c = r[w-1]; end
            RCL: begin k = n % (w + 1); t = ((ring << k) | (ring >> (w + 1 - k))) & rm; r = t; c = t[w]; end
            RCR: begin k = n % (w + 1); t = ((ring >> k) | (ring << (w + 1 - k))) & rm; r = t; c = t[w]; end
            default: ;
        endcase
        r = r & m;
        f = fi;
        f[CF_IDX] = c;
        f[SF_IDX] = r[w-1];
        f[ZF_IDX] = r == 64'd0;
        f[PF_IDX] = ~^r[7:0];
        case (op)
            SHL:      f[OF_IDX] = a[w-1] ^ r[w-1];
            SHR:      f[OF_IDX] = a[w-1];
            ROL, RCL: f[OF_IDX] = a[w-1] ^ a[w-2];
            ROR:      f[OF_IDX] = a[w-1] ^ a[0];
            RCR:      f[OF_IDX] = a[w-1] ^ fi[CF_IDX];
            default:  f[OF_IDX] = 1'b0;
        endcase
        return {r[31:0], f};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int W = (g == 0) ? 16 : 32;
        localparam int S = (g == 0) ? 1 : 4;
        localparam bit M = (g == 0);
        logic rn, st, fl, b8, busy, dn, ended;
        ShiftOp_t op;
        logic [W-1:0] a, o;
        logic [7:0] cnt;
        logic [15:0] fin, fo;
        exp_t q[$];

        shift_rotate_unit #(.WIDTH(W), .STEP(S), .MASK_COUNT(M)) dut (
            .clk(clk), .reset_n(rn), .start(st), .flush(fl), .op(op), .is_8_bit(b8),
            .a(a), .count(cnt), .flags_in(fin), .busy(busy), .done(dn), .out(o), .flags_out(fo)
        );

        always @(negedge clk) begin
            exp_t e;
            if (rn && dn) begin
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL inst%0d unexpected_done: done=1 required 0 at cycle %0d", g, cyc);
                end else begin
                    e = q.pop_front();
                    chk(g, "out", 64'(o), 64'(e.o[W-1:0]));
                    chk(g, "flags_out", 64'(fo), 64'(e.f));
                    chk(g, "done_cycle", 64'(cyc), 64'(e.due));
                end
            end
        end

        initial begin
            exp_t e;
            vec_t v;
            logic [W-1:0] po;
            logic [15:0] pf;
            int n, t;
            ended = 1'b0;
            rn = 1'b0; st = 1'b0; fl = 1'b0; op = SHL; b8 = 1'b0; a = '0; cnt = '0; fin = '0;
            repeat (3) @(negedge clk);
            chk(g, "reset_busy", 64'(busy), 64'd0);
            chk(g, "reset_done", 64'(dn), 64'd0);
            chk(g, "reset_out", 64'(o), 64'd0);
            chk(g, "reset_flags", 64'(fo), 64'd0);
            rn = 1'b1;
            @(negedge clk);
            for (int j = 0; j < NDIR + NRND; j++) begin
                if (j < NDIR) v = dvec(j);
                else begin
                    v.op = ShiftOp_t'($urandom_range(0, 6));
                    v.b8 = 1'($urandom);
                    v.a  = $urandom;
                    v.c  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
                    v.f  = 16'($urandom);
                    v.bb = $urandom_range(0, 2) == 0;
                end
                if (!v.bb) repeat ($urandom_range(1, 2)) @(negedge clk);
                op = v.op; b8 = v.b8; a = W'(v.a); cnt = v.c; fin = v.f; st = 1'b1;
                n = M ? int'(v.c[4:0]) : int'(v.c);
                {e.o, e.f} = model(v.b8 ? 8 : W, v.op, 32'(a), n, v.f);
                e.due = cyc + 1 + (n + S - 1) / S;
                q.push_back(e);
                vectors++;
                @(negedge clk);
                t = 0;
                // starts raised while running must be ignored
                while (!dn && t < 300) begin
                    st = 1'($urandom);
                    a = W'($urandom);
                    cnt = 8'($urandom);
                    @(negedge clk);
                    t++;
                end
                st = 1'b0;
                if (!dn) begin
                    miscompares++;
                    $display("FAIL inst%0d done_timeout: done=0 required 1 after %0d cycles", g, t);
                end
            end
            repeat (2) @(negedge clk);
            po = o;
            pf = fo;
            op = SHL; b8 = 1'b0; a = '1; cnt = 8'd40; fin = 16'h0000; st = 1'b1;
            vectors++;
            @(negedge clk);
            st = 1'b0;
            @(negedge clk);
            fl = 1'b1;
            @(negedge clk);
            fl = 1'b0;
            chk(g, "flush_busy", 64'(busy), 64'd0);
            chk(g, "flush_done", 64'(dn), 64'd0);
            chk(g, "flush_out", 64'(o), 64'(po));
            chk(g, "flush_flags", 64'(fo), 64'(pf));
            repeat (60) @(negedge clk);
            chk(g, "flush_idle_busy", 64'(busy), 64'd0);
            op = ROR; a = W'($urandom | 1); cnt = 8'd12; fin = 16'hFFFF; st = 1'b1;
            vectors++;
            @(negedge clk);
            st = 1'b0;
            @(negedge clk);
            rn = 1'b0;
            #1;
            chk(g, "async_reset_out", 64'(o), 64'd0);
            chk(g, "async_reset_flags", 64'(fo), 64'd0);
            chk(g, "async_reset_busy", 64'(busy), 64'd0);
            @(negedge clk);
            rn = 1'b1;
            repeat (20) @(negedge clk);
            chk(g, "post_reset_busy", 64'(busy), 64'd0);
            chk(g, "scoreboard_drained", 64'(q.size()), 64'd0);
            ended = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(inst[0].ended && inst[1].ended) && t < 80000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 80000) begin
            miscompares++;
            $display("FAIL run_timeout: ended=%0b%0b required 11", inst[1].ended, inst[0].ended);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
